// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue: default widths and the sizing helpers
// used to derive pointer and occupancy widths from the FIFO depth.
// No logic lives here; the entry struct is declared in the top from these widths.
package dispatch_queue_pkg;

  localparam int DQ_CONTROL_DEF    = 2;
  localparam int DQ_DATA_WIDTH_DEF = 32;
  localparam int DQ_DEPTH_DEF      = 4;

  // Pointer width for a power-of-two depth; a 1-entry FIFO still needs one bit.
  function automatic int dq_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, so full and empty stay distinct.
  function automatic int dq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dispatch_queue_demux.sv
// Purpose : 1-to-2**CONTROL demultiplexer; i_inp appears on lane i_sel, zeros elsewhere.
// Ports   : i_sel (lane index), i_inp (payload), o_out (unpacked array of lanes).
// Latency : purely combinational; no flow control of its own.
module dispatch_queue_demux
  import dispatch_queue_pkg::*;
#(
  parameter int CONTROL = DQ_CONTROL_DEF,
  parameter int WIDTH   = DQ_DATA_WIDTH_DEF
) (
  input  logic [CONTROL-1:0] i_sel,
  input  logic [WIDTH-1:0]   i_inp,
  output logic [WIDTH-1:0]   o_out [2**CONTROL]
);

  always_comb begin
    for (int i = 0; i < 2**CONTROL; i++) begin
      o_out[i] = (i_sel == CONTROL'(i)) ? i_inp : '0;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// Purpose : in-order request FIFO whose head is steered to one of 2**CONTROL consumers.
// Latency : 1 cycle push-to-present (no bypass); 1 request/cycle sustained when head consumer ready.
// Backpr. : in_ready depends only on occupancy; a stalled head blocks every later entry.
// Ports   : clk/reset (async, active-high), flush (sync clear), in_valid/in_ready/in_data/in_dest
//           producer side, out_valid/out_ready/out_data per-destination consumer side, count occupancy.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter  int CONTROL    = DQ_CONTROL_DEF,
  parameter  int DATA_WIDTH = DQ_DATA_WIDTH_DEF,
  parameter  int DEPTH      = DQ_DEPTH_DEF,
  localparam int NDEST      = 2**CONTROL,
  localparam int CNT_W      = dq_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CONTROL-1:0]    in_dest,
  output logic [NDEST-1:0]      out_valid,
  input  logic [NDEST-1:0]      out_ready,
  output logic [DATA_WIDTH-1:0] out_data [NDEST],
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = dq_ptr_w(DEPTH);

  typedef struct packed {
    logic [CONTROL-1:0]    dest;
    logic [DATA_WIDTH-1:0] data;
  } dq_entry_t;

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  dq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  dq_entry_t             w_head;
  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [0:0]            w_vld_lane [NDEST];

  assign w_head     = r_mem[r_rd_ptr];
  assign w_nonempty = (r_count != '0);
  assign in_ready   = (r_count != CNT_W'(DEPTH));
  assign count      = r_count;

  assign w_push = in_valid & in_ready;
  // Only the lane the head is steered to may pop it; other out_ready bits are ignored.
  // w_nonempty masks the never-written storage read while empty.
  assign w_pop  = w_nonempty & out_ready[w_head.dest];

  // Zero the payload when empty so every lane reads zero, independent of stale storage.
  assign w_head_data = w_nonempty ? w_head.data : '0;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= '{dest: in_dest, data: in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Flush wins over any push/pop in the same cycle; an offered request is dropped.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so the increment wraps naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  dispatch_queue_demux #(
    .CONTROL (CONTROL),
    .WIDTH   (DATA_WIDTH)
  ) u_data_demux (
    .i_sel (w_head.dest),
    .i_inp (w_head_data),
    .o_out (out_data)
  );

  dispatch_queue_demux #(
    .CONTROL (CONTROL),
    .WIDTH   (1)
  ) u_valid_demux (
    .i_sel (w_head.dest),
    .i_inp (w_nonempty),
    .o_out (w_vld_lane)
  );

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NDEST; i++) begin
      out_valid[i] = w_vld_lane[i][0];
    end
  end

  a_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(out_valid));
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) r_count <= CNT_W'(DEPTH));
  a_valid_iff:    assert property (@(posedge clk) disable iff (reset)
                                   ((out_valid != '0) == w_nonempty));

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (CONTROL=2, DATA_WIDTH=32, DEPTH=4) with a
// queue-based reference model checked every cycle and literal expectations per scenario.
module tb_dispatch_queue;

  localparam int CONTROL = 2;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int NDEST   = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data [NDEST];
  logic [2:0]    count;

  dispatch_queue #(.CONTROL(CONTROL), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a plain queue of outstanding requests in arrival order.
  typedef struct {
    logic [1:0]    dest;
    logic [DW-1:0] data;
  } ent_t;
  ent_t mq[$];

  // Compare on the falling edge, then advance the model to the state after the next rising edge.
  always @(negedge clk) begin
    logic [3:0]    exp_vld;
    logic [DW-1:0] exp_dat [NDEST];
    bit do_push, do_pop;
    if (reset) mq.delete();
    exp_vld = '0;
    for (int i = 0; i < NDEST; i++) exp_dat[i] = '0;
    if (mq.size() != 0) begin
      exp_vld[mq[0].dest] = 1'b1;
      exp_dat[mq[0].dest] = mq[0].data;
    end
    check("model_count", 64'(count), 64'(mq.size()));
    check("model_in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    check("model_out_valid", 64'(out_valid), 64'(exp_vld));
    for (int i = 0; i < NDEST; i++) check("model_out_data", 64'(out_data[i]), 64'(exp_dat[i]));
    if (!reset) begin
      do_push = in_valid && (mq.size() != DEPTH);
      do_pop  = (mq.size() != 0) && out_ready[mq[0].dest];
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) begin
          void'(mq.pop_front());
          n_pops++;
        end
        if (do_push) mq.push_back('{dest: in_dest, data: in_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] d, input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  int pops_before;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < NDEST; i++) check("rst_out_data", 64'(out_data[i]), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Single request to dest 2, consumer not ready.
    push1(2'd2, 32'hA5);
    check("single_valid", 64'(out_valid), 64'b0100);
    check("single_data2", 64'(out_data[2]), 64'hA5);
    check("single_data0", 64'(out_data[0]), 64'd0);
    check("single_data3", 64'(out_data[3]), 64'd0);
    check("single_count", 64'(count), 64'd1);
    out_ready = 4'b0100;
    tick();
    check("single_pop_valid", 64'(out_valid), 64'd0);
    check("single_pop_count", 64'(count), 64'd0);
    out_ready = '0;

    // Fill to full, offer a fifth, then drain in order.
    for (int i = 0; i < 4; i++) push1(2'(i), 32'h100 + i);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    push1(2'd0, 32'hBAD);
    check("full_reject_count", 64'(count), 64'd4);
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(out_valid), 64'(4'b0001 << i));
      check("drain_data", 64'(out_data[i]), 64'(32'h100 + i));
      tick();
    end
    check("drain_empty", 64'(count), 64'd0);
    out_ready = 4'b1000;

    // Head-of-line: dest1 head stalls while dest3 consumer is ready.
    push1(2'd1, 32'h11);
    push1(2'd3, 32'h33);
    for (int k = 0; k < 5; k++) begin
      check("hol_valid", 64'(out_valid), 64'b0010);
      check("hol_count", 64'(count), 64'd2);
      tick();
    end
    out_ready = 4'b1010;
    tick();
    check("hol_second_valid", 64'(out_valid), 64'b1000);
    check("hol_second_data", 64'(out_data[3]), 64'h33);
    tick();
    check("hol_done_count", 64'(count), 64'd0);

    // Streaming at occupancy 1 through many pointer wraps.
    out_ready = 4'b0001;
    pops_before = n_pops;
    in_valid = 1'b1; in_dest = 2'd0; in_data = 32'h200;
    tick();
    for (int k = 1; k <= 20; k++) begin
      in_data = 32'h200 + k;
      check("stream_count", 64'(count), 64'd1);
      check("stream_data", 64'(out_data[0]), 64'(32'h200 + k - 1));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(count), 64'd0);
    check("stream_delivered", 64'(n_pops - pops_before), 64'd21);
    out_ready = '0;

    // Flush at occupancy 3 with a simultaneous offer.
    push1(2'd0, 32'h300);
    push1(2'd1, 32'h301);
    push1(2'd2, 32'h302);
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_dest = 2'd3; in_data = 32'hF00;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    tick();
    check("flush_dropped", 64'(count), 64'd0);

    // Asynchronous reset mid-operation.
    push1(2'd1, 32'h400);
    push1(2'd2, 32'h401);
    check("pre_arst_count", 64'(count), 64'd2);
    check("pre_arst_valid", 64'(out_valid), 64'b0010);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_data1", 64'(out_data[1]), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    push1(2'd3, 32'h500);
    check("post_arst_valid", 64'(out_valid), 64'b1000);
    check("post_arst_data", 64'(out_data[3]), 64'h500);
    out_ready = 4'b1000;
    tick();
    check("post_arst_pop", 64'(count), 64'd0);
    out_ready = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Buffered request router feeding the per-destination fan-out.
- Accepts a stream of (data, destination index) requests with valid/ready handshake and holds them in a small in-order FIFO.
- Presents the head entry to exactly one of 2**CONTROL consumers, each with its own valid/ready pair. Non-selected lanes carry zero data.
- Sits between a single producer (e.g. memory/request stage) and N destination units (cache banks, functional units).

Parameters:
CONTROL, 2, destination index width; number of destinations = 2**CONTROL
DATA_WIDTH, 32, payload width
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of all queued entries
in_valid  input  1  producer offers a request
in_ready  output  1  queue can accept a request this cycle
in_data  input  DATA_WIDTH  request payload
in_dest  input  CONTROL  destination index of the request
out_valid  output  2**CONTROL  one-hot valid per destination; all zero when empty
out_ready  input  2**CONTROL  per-destination accept
out_data  output  DATA_WIDTH x 2**CONTROL (unpacked)  per-destination payload; zero on non-selected lanes
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high. While asserted, rd_ptr = wr_ptr = 0, count = 0, in_ready = 1, out_valid = 0, all out_data lanes = 0. Storage array is not reset.
- Storage: DEPTH entries of {dest, data}. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by count, so full and empty are unambiguous.
- in_ready = (count != DEPTH). It depends only on state; there is no combinational path from out_ready.
- push = in_valid & in_ready; pop = (count != 0) & out_ready[head.dest].
- Head presentation, combinational from state:
  - When count != 0: out_valid[head.dest] = 1, all other out_valid bits = 0; out_data[head.dest] = head.data, other lanes = 0.
  - When empty: all out_valid and out_data are 0.
- out_ready bits of non-selected lanes are ignored.
- Latency: no bypass. A request pushed into an empty queue appears on out_valid in the following cycle. Minimum latency is 1 cycle; sustained throughput is 1 request/cycle when the head's consumer is always ready.
- Ordering: strict FIFO across all destinations. A stalled head blocks later entries to other destinations (head-of-line blocking is intended).
- Count update:
  - push & !pop: +1
  - pop & !push: -1
  - both or neither: unchanged
- Full: in_ready = 0. A pop in the same cycle frees a slot, but the push is not accepted until the next cycle.
- Simultaneous push and pop at count == 1: the head advances to the new entry; count stays 1.
- flush: next edge sets pointers and count to 0. Flush overrides push and pop in that cycle; an offered request is dropped and not counted. in_ready stays as computed from pre-flush state.
- Reset mid-operation: all in-flight entries are discarded; outputs go to their reset values immediately (asynchronous assertion). Deassertion is synchronous to clk externally.
- Payload and dest are held stable at the outputs while the head consumer's out_ready = 0.
- Assertions for verification:
  - out_valid is always one-hot or zero.
  - count <= DEPTH.
  - out_valid == 0 iff count == 0.

Decomposition:
- Shared package (utility pkg): typedef dq_entry_t {logic [CONTROL-1:0] dest; logic [DATA_WIDTH-1:0] data;} as a parameterised struct macro or localparam widths. Also a PTR_W = $clog2(DEPTH) helper function.
- Sub-module: reuse the existing demux utility twice:
  - demux(CONTROL, DATA_WIDTH) for out_data fan-out.
  - demux(CONTROL, 1) with inp = (count != 0) for out_valid.
- The FIFO storage/pointer logic stays in this module.

Test Plan:
- Reset with CONTROL=2, DEPTH=4: check count=0, in_ready=1, out_valid=4'b0000, all out_data=0 during and after reset.
- Push (data=0xA5, dest=2) into empty queue, all out_ready=0: next cycle out_valid=4'b0100, out_data[2]=0xA5, lanes 0/1/3 = 0, count=1. Assert out_ready[2]: next cycle out_valid=0, count=0.
- Push 4 requests to dests 0,1,2,3 with all out_ready=0: count=4, in_ready=0, a 5th in_valid is not accepted. Then hold out_ready=4'b1111: outputs drain in order 0,1,2,3, one per cycle.
- Head-of-line: queue (dest1, 0x11) then (dest3, 0x33), out_ready=4'b1000: no pop, out_valid=4'b0010 held for 5 cycles. Set out_ready[1]=1: 0x11 pops, then 0x33 pops next cycle.
- Streaming at count=1: push every cycle with dest=0, out_ready[0]=1: count stays 1 and one item is delivered per cycle for 20 cycles. Verify wrap-around of pointers past DEPTH with no data corruption.
- Flush with count=3 plus simultaneous in_valid: next cycle count=0, out_valid=0, and the offered request is absent. Asynchronous reset asserted mid-stream with count=2 immediately zeroes out_valid.
